// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: state encodings, access-size codes and default I/O base
// shared by the memory arbiter files.
package memory_arbiter_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t INS_RD  = 2'd1;
  localparam state_t DATA_RD = 2'd2;
  localparam state_t DATA_WR = 2'd3;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [31:0] IO_BASE_DEF = 32'h00030000;
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    return size == SZ_BYTE ? 2'd0 : size == SZ_HALF ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/memory_arbiter_grant.sv
// memory_arbiter_grant: picks data vs instruction requester on acceptance.
// MEMORY_ARBITER_RR_EN selects round-robin; otherwise data always wins.
module memory_arbiter_grant (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_en,
  input  logic i_ins_req,
  input  logic i_data_req,
  output logic o_gnt_data
);
`ifdef MEMORY_ARBITER_RR_EN
  logic r_last_data;
  assign o_gnt_data = i_data_req && (!i_ins_req || !r_last_data);
  always_ff @(posedge clk_in)
    if (rst_in) r_last_data <= 1'b0;
    else if (i_en) r_last_data <= o_gnt_data;
`else
  logic w_unused;
  assign w_unused = ^{clk_in, rst_in, i_en, i_ins_req};
  assign o_gnt_data = i_data_req;
`endif
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises instruction fetches and data loads/stores onto
// a byte-wide memory port. Round-robin tie-break under MEMORY_ARBITER_RR_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        ins_req,
  input  logic [31:0] ins_addr,
  output logic [31:0] ins_data,
  output logic        ins_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;
  logic        r_drain;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_ins_done;
  logic        r_data_done;
  logic [31:0] r_ins_data;
  logic [31:0] r_data_rdata;
  logic        w_idle;
  logic        w_rd;
  logic        w_wr;
  logic        w_req;
  logic        w_gnt_data;
  logic        w_stall;
  logic        w_cap;
  logic [1:0]  w_idx;
  logic [31:0] w_a;
  logic [31:0] w_word;
  assign w_idle = r_state == IDLE;
  assign w_rd   = r_state == INS_RD || r_state == DATA_RD;
  assign w_wr   = r_state == DATA_WR;
  assign w_req  = (ins_req || data_req) && !flush_pipline;
  assign w_a    = r_addr + {30'd0, r_cnt};
  assign w_stall = io_buffer_full && w_a >= IO_BASE;
  // Read data lags its address by one cycle; after the last address the
  // drain cycle picks up the final byte.
  assign w_cap  = w_rd && (r_drain || r_cnt != 2'd0);
  assign w_idx  = r_drain ? r_cnt : r_cnt - 2'd1;
  assign w_word = r_buf | ({24'd0, mem_din} << {w_idx, 3'b000});
  assign mem_a    = (w_rd && !r_drain) || w_wr ? w_a : 32'd0;
  assign mem_wr   = w_wr && rdy_in && !w_stall;
  assign mem_dout = w_wr ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'd0;
  assign ins_done   = r_ins_done && rdy_in;
  assign data_done  = r_data_done && rdy_in;
  assign ins_data   = r_ins_data;
  assign data_rdata = r_data_rdata;
  memory_arbiter_grant u_grant (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_en       (rdy_in && w_idle && w_req),
    .i_ins_req  (ins_req),
    .i_data_req (data_req),
    .o_gnt_data (w_gnt_data)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_cnt        <= 2'd0;
      r_last       <= 2'd0;
      r_drain      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_buf        <= 32'd0;
      r_ins_done   <= 1'b0;
      r_data_done  <= 1'b0;
      r_ins_data   <= 32'd0;
      r_data_rdata <= 32'd0;
    end else if (rdy_in) begin
      r_ins_done  <= 1'b0;
      r_data_done <= 1'b0;
      if (w_idle) begin
        if (w_req) begin
          r_state <= w_gnt_data ? (data_we ? DATA_WR : DATA_RD) : INS_RD;
          r_addr  <= w_gnt_data ? data_addr : ins_addr;
          r_last  <= w_gnt_data ? last_idx(data_size) : 2'd3;
          r_wdata <= data_wdata;
          r_cnt   <= 2'd0;
          r_drain <= 1'b0;
          r_buf   <= 32'd0;
        end
      end else if (w_rd) begin
        if (flush_pipline) r_state <= IDLE;
        else begin
          if (w_cap) r_buf <= w_word;
          if (r_drain) begin
            r_state <= IDLE;
            if (r_state == INS_RD) begin
              r_ins_done <= 1'b1;
              r_ins_data <= w_word;
            end else begin
              r_data_done  <= 1'b1;
              r_data_rdata <= w_word;
            end
          end else if (r_cnt == r_last) r_drain <= 1'b1;
          else r_cnt <= r_cnt + 2'd1;
        end
      end else if (!w_stall) begin
        if (r_cnt == r_last) begin
          r_state     <= IDLE;
          r_data_done <= 1'b1;
        end else r_cnt <= r_cnt + 2'd1;
      end
    end
  end
endmodule
